clk_sel_det: RTL and testbench
==============================

Name: clk_sel_det

Overview:
- Receive-side companion to the clock-select divider. Measures the period of a divided clock derived from pclk and decodes it back to the 2-bit select code that produced it.
- Encoding: sel 00/01/10/11 = divide by 2/4/8/16.
- Reports the decoded select, lock status, illegal-period errors and loss of clock.
- Sits in the clock-monitor path next to the divider; it is also used by benches as a self-checking monitor.

Parameters:
- CNT_W, 8, width of the period counter and the period output; the counter saturates at 2^CNT_W-1.
- LOCK_CNT, 2, number of consecutive identical legal periods required to assert locked (range 1..15).
- TIMEOUT, 64, pclk cycles without a detected rising edge before no_clk is asserted (must be < 2^CNT_W).

Ports:
- pclk, input, 1, system clock; all logic is on its rising edge.
- presetn, input, 1, asynchronous active-low reset.
- clk_in, input, 1, divided clock under test; treated as asynchronous data.
- sel_det, output, 2, decoded select code of the last locked period.
- locked, output, 1, high while the measured period is stable and legal.
- err, output, 1, one-cycle pulse when a completed period is not 2/4/8/16.
- no_clk, output, 1, high when no clk_in rising edge has been seen for TIMEOUT cycles.
- period, output, CNT_W, last completed period in pclk cycles.

Behaviour:
- Reset (async assert, sync release): all outputs are 0; sync flops, counter and match count are 0; state is IDLE.
- Input conditioning: clk_in passes through a 2-flop synchronizer s1->s2, then s3 <= s2. rise = s2 & ~s3.
  - rise is asserted 3 pclk edges after the clk_in transition is captured.
- Cycle counter cnt:
  - On rise: cnt <= 1.
  - Otherwise: cnt <= cnt+1, saturating at all-ones.
- Period capture: on a rise that is not the first since IDLE, period <= cnt, with its value before the reset. All outputs are registered; period and decode results appear one cycle after rise.
- Legal map: 2->00, 4->01, 8->10, 16->11. Any other value is illegal.
- States:
  - IDLE: waiting for the first rise. On rise -> MEASURE; no period is captured.
  - MEASURE: on each rise, evaluate the period.
    - Illegal period: err pulse, match=0.
    - Legal and equal to the previous period: match++. Otherwise match=1.
    - When match reaches LOCK_CNT: sel_det <= code, locked=1, -> LOCKED.
  - LOCKED: on each rise, evaluate the period.
    - Same period: stay.
    - Different legal period: locked=0, match=1, -> MEASURE. sel_det holds the old value until relock.
    - Illegal period: locked=0, err pulse, match=0, -> MEASURE.
  - Any state, when cnt reaches TIMEOUT without a rise: no_clk=1, locked=0, match=0, -> IDLE. sel_det and period are held.
- no_clk clears on the next rise, in the same cycle IDLE->MEASURE is taken.
- If rise coincides with cnt==TIMEOUT, rise wins; no timeout is flagged.
- LOCK_CNT=1: lock on the first legal period after IDLE.
- Reset mid-operation aborts immediately: outputs are 0, state is IDLE; no err or no_clk pulse on release.
- clk_in held high or low: no rise occurs, so timeout applies.
- Sizing: RTL of roughly 150-250 lines, one FSM, no multipliers.

Test Plan:
- Reset then divide-by-4: hold presetn=0 for 10 cycles, then drive clk_in at period 4.
  - Outputs are 0 during reset.
  - After the 1st rise plus 2 full periods: locked=1, sel_det=01, period=4.
  - Check lock lands exactly 1 cycle after the 3rd rise pulse.
- Divider sweep: select 00, 01, 10, 11 in turn, 800 time units each.
  - sel_det follows 00/01/10/11 with locked re-asserting each time.
  - locked drops on the first changed period; err stays 0 throughout.
- Illegal period: drive period 6 for 5 periods, then period 8.
  - err pulses 1 cycle per completed period of 6; locked=0; period=6.
  - After 2 periods of 8: locked=1, sel_det=10.
- Timeout: lock at divide-by-16, then hold clk_in=0.
  - no_clk=1 and locked=0 exactly when cnt reaches 64; sel_det=11 and period=16 are held.
  - Resume clocking: no_clk clears on the first rise and relock follows.
- Reset mid-lock: assert presetn=0 while locked at divide-by-2.
  - All outputs go to 0 asynchronously, without waiting for a pclk edge.
  - After release: relock takes LOCK_CNT full periods.
- LOCK_CNT=1 build: the first legal period of 8 gives locked=1 one cycle after the 2nd rise.

Source files
------------

// File: rtl/clk_sel_det.sv
// Divided-clock period detector: measures clk_in in pclk cycles and
// decodes the divide-by-2/4/8/16 select code, with lock, error and timeout.
module clk_sel_det #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             clk_in,
  output logic [1:0]       sel_det,
  output logic             locked,
  output logic             err,
  output logic             no_clk,
  output logic [CNT_W-1:0] period
);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    LOCKED
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(TIMEOUT);
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_CNT);

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [3:0]       match_q, match_d, match_nxt;
  logic [1:0]       sel_q, sel_d, code;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             no_clk_q, no_clk_d;
  logic             rise, tmo, legal, same, hit;

  assign rise = s2_q & ~s3_q;
  assign tmo  = (cnt_q == CNT_TMO) & ~rise;
  assign same = (cnt_q == period_q);

  always_comb begin
    legal = 1'b1;
    code  = 2'd0;
    unique case (1'b1)
      cnt_q == CNT_W'(2):  code = 2'd0;
      cnt_q == CNT_W'(4):  code = 2'd1;
      cnt_q == CNT_W'(8):  code = 2'd2;
      cnt_q == CNT_W'(16): code = 2'd3;
      default:             legal = 1'b0;
    endcase
  end

  always_comb begin
    match_nxt = 4'd0;
    if (legal) match_nxt = same ? match_q + 4'd1 : 4'd1;
    hit = legal && (match_nxt >= LOCK_N);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (rise) cnt_d = CNT_ONE;
    else if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tmo) begin
      state_d = IDLE;
    end else if (rise) begin
      unique case (state_q)
        IDLE:    state_d = MEASURE;
        MEASURE: if (hit) state_d = LOCKED;
        LOCKED:  if (!(legal && same)) state_d = MEASURE;
        default: state_d = IDLE;
      endcase
    end
  end

  // A rise always beats a coincident timeout
  always_comb begin
    match_d  = match_q;
    sel_d    = sel_q;
    locked_d = locked_q;
    err_d    = 1'b0;
    no_clk_d = no_clk_q;
    period_d = period_q;
    if (tmo) begin
      no_clk_d = 1'b1;
      locked_d = 1'b0;
      match_d  = 4'd0;
    end else if (rise) begin
      no_clk_d = 1'b0;
      if (state_q != IDLE) period_d = cnt_q;
      unique case (state_q)
        MEASURE: begin
          err_d   = ~legal;
          match_d = match_nxt;
          if (hit) begin
            sel_d    = code;
            locked_d = 1'b1;
          end
        end
        LOCKED: begin
          if (!(legal && same)) begin
            locked_d = 1'b0;
            err_d    = ~legal;
            match_d  = match_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
      match_q  <= 4'd0;
      sel_q    <= 2'd0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      no_clk_q <= 1'b0;
    end else begin
      s1_q     <= clk_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      match_q  <= match_d;
      sel_q    <= sel_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      no_clk_q <= no_clk_d;
    end
  end

  assign sel_det = sel_q;
  assign locked  = locked_q;
  assign err     = err_q;
  assign no_clk  = no_clk_q;
  assign period  = period_q;

endmodule

// File: tb/tb_clk_sel_det.sv
// Bench for clk_sel_det: two builds (LOCK_CNT 2 and 1) against an
// edge-timestamp reference model, directed scenarios plus random stimulus.
module tb_clk_sel_det;

  localparam int TMO  = 64;
  localparam int MAXC = 255;
  localparam int M_IDLE = 0;
  localparam int M_MEAS = 1;
  localparam int M_LOCK = 2;

  logic       pclk;
  logic       presetn;
  logic       clk_in;
  logic [1:0] sel0, sel1;
  logic       lk0, lk1, err0, err1, nc0, nc1;
  logic [7:0] per0, per1;

  int  n_chk = 0;
  int  n_fail = 0;
  int  errs0 = 0;
  bit  rst_req = 0;

  bit  hist[$];
  int  e_n;
  int  last_r;
  bit  have_r;
  int  lkc[2] = '{2, 1};
  int  mode[2], run[2];
  int  m_sel[2], m_lk[2], m_err[2], m_nc[2], m_per[2];

  clk_sel_det #(.CNT_W(8), .LOCK_CNT(2), .TIMEOUT(TMO)) u0 (
    .pclk(pclk), .presetn(presetn), .clk_in(clk_in),
    .sel_det(sel0), .locked(lk0), .err(err0),
    .no_clk(nc0), .period(per0)
  );

  clk_sel_det #(.CNT_W(8), .LOCK_CNT(1), .TIMEOUT(TMO)) u1 (
    .pclk(pclk), .presetn(presetn), .clk_in(clk_in),
    .sel_det(sel1), .locked(lk1), .err(err1),
    .no_clk(nc1), .period(per1)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit xat(input int j);
    if (j >= 1 && j <= hist.size()) return hist[j-1];
    return 1'b0;
  endfunction

  function automatic int code_of(input int c);
    if (c == 2) return 0;
    if (c == 4) return 1;
    if (c == 8) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    hist.delete();
    e_n = 0;
    last_r = 0;
    have_r = 0;
    for (int i = 0; i < 2; i++) begin
      mode[i] = M_IDLE; run[i] = 0;
      m_sel[i] = 0; m_lk[i] = 0; m_err[i] = 0;
      m_nc[i] = 0; m_per[i] = 0;
    end
  endtask

  task automatic upd(input int i, input bit r, input int c);
    bit legal, same;
    m_err[i] = 0;
    if (r) begin
      m_nc[i] = 0;
      if (mode[i] == M_IDLE) begin
        mode[i] = M_MEAS;
      end else begin
        legal = (c == 2 || c == 4 || c == 8 || c == 16);
        same = (c == m_per[i]);
        if (!legal) begin
          m_err[i] = 1; run[i] = 0; m_lk[i] = 0; mode[i] = M_MEAS;
        end else if (mode[i] == M_LOCK) begin
          if (!same) begin
            m_lk[i] = 0; run[i] = 1; mode[i] = M_MEAS;
          end
        end else begin
          run[i] = same ? run[i] + 1 : 1;
          if (run[i] >= lkc[i]) begin
            m_lk[i] = 1; m_sel[i] = code_of(c); mode[i] = M_LOCK;
          end
        end
        m_per[i] = c;
      end
    end else if (c == TMO) begin
      m_nc[i] = 1; m_lk[i] = 0; run[i] = 0; mode[i] = M_IDLE;
    end
  endtask

  // A rise is seen at edge e when clk_in was low at e-3 and high at e-2
  task automatic model_edge();
    bit r;
    int c;
    if (!presetn) return;
    e_n++;
    r = xat(e_n - 2) && !xat(e_n - 3);
    c = have_r ? e_n - last_r : e_n - 1;
    if (c > MAXC) c = MAXC;
    hist.push_back(clk_in);
    for (int i = 0; i < 2; i++) upd(i, r, c);
    if (r) begin
      have_r = 1;
      last_r = e_n;
    end
  endtask

  task automatic cyc(input logic v);
    @(negedge pclk);
    if (rst_req && presetn) model_reset();
    presetn = !rst_req;
    clk_in = v;
    @(posedge pclk);
    model_edge();
  endtask

  task automatic run_clk(input int p, input int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < p; i++) cyc(i < p / 2);
  endtask

  task automatic async_rst(input int n);
    #2;
    presetn = 1'b0;
    rst_req = 1'b1;
    model_reset();
    repeat (n) cyc(clk_in);
    rst_req = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge pclk);
      #1;
      chk("sel0", 32'(sel0), m_sel[0]);
      chk("lk0", 32'(lk0), m_lk[0]);
      chk("err0", 32'(err0), m_err[0]);
      chk("nc0", 32'(nc0), m_nc[0]);
      chk("per0", 32'(per0), m_per[0]);
      chk("sel1", 32'(sel1), m_sel[1]);
      chk("lk1", 32'(lk1), m_lk[1]);
      chk("err1", 32'(err1), m_err[1]);
      chk("nc1", 32'(nc1), m_nc[1]);
      chk("per1", 32'(per1), m_per[1]);
      if (err0) errs0++;
    end
  end

  initial begin
    int ptab[12] = '{2, 4, 8, 16, 2, 4, 8, 16, 3, 6, 12, 5};
    presetn = 1'b0;
    clk_in = 1'b0;
    model_reset();

    rst_req = 1'b1;
    repeat (10) cyc(1'b0);
    #2;
    chk("rst_lk", 32'(lk0), 0);
    chk("rst_per", 32'(per0), 0);
    chk("rst_nc", 32'(nc0), 0);
    rst_req = 1'b0;

    for (int i = 0; i < 12; i++) begin
      cyc((i % 4) < 2);
      #2;
      if (i == 5) chk("d4_lk1_early", 32'(lk1), 0);
      if (i == 6) chk("d4_lk1", 32'(lk1), 1);
      if (i == 9) chk("d4_lk0_early", 32'(lk0), 0);
      if (i == 10) begin
        chk("d4_lk0", 32'(lk0), 1);
        chk("d4_sel", 32'(sel0), 1);
        chk("d4_per", 32'(per0), 4);
      end
    end
    run_clk(4, 3);

    errs0 = 0;
    for (int s = 0; s < 4; s++) begin
      run_clk(2 << s, 80 / (2 << s));
      #2;
      chk("sweep_lk", 32'(lk0), 1);
      chk("sweep_sel", 32'(sel0), s);
    end
    chk("sweep_err", errs0, 0);

    errs0 = 0;
    run_clk(6, 5);
    #2;
    chk("ill_lk", 32'(lk0), 0);
    chk("ill_per", 32'(per0), 6);
    run_clk(8, 3);
    #2;
    chk("ill_relk", 32'(lk0), 1);
    chk("ill_sel", 32'(sel0), 2);
    chk("ill_errs", errs0, 5);

    run_clk(16, 4);
    #2;
    chk("to_lk", 32'(lk0), 1);
    repeat (50) cyc(1'b0);
    #2;
    chk("to_early", 32'(nc0), 0);
    cyc(1'b0);
    #2;
    chk("to_nc", 32'(nc0), 1);
    chk("to_lk0", 32'(lk0), 0);
    chk("to_sel", 32'(sel0), 3);
    chk("to_per", 32'(per0), 16);
    cyc(1'b1);
    cyc(1'b1);
    #2;
    chk("to_hold", 32'(nc0), 1);
    cyc(1'b1);
    #2;
    chk("to_clr", 32'(nc0), 0);
    repeat (5) cyc(1'b1);
    repeat (8) cyc(1'b0);
    run_clk(16, 3);
    #2;
    chk("to_relk", 32'(lk0), 1);

    run_clk(2, 6);
    #2;
    chk("ml_lk", 32'(lk0), 1);
    chk("ml_per", 32'(per0), 2);
    presetn = 1'b0;
    rst_req = 1'b1;
    model_reset();
    #1;
    chk("ml_async_lk", 32'(lk0), 0);
    chk("ml_async_per", 32'(per0), 0);
    repeat (3) cyc(1'b0);
    rst_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc((i % 2) == 0);
      #2;
      if (i == 4) begin
        chk("ml_lk1", 32'(lk1), 1);
        chk("ml_lk0_early", 32'(lk0), 0);
      end
      if (i == 6) chk("ml_relk", 32'(lk0), 1);
    end

    rst_req = 1'b1;
    repeat (2) cyc(1'b0);
    rst_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc((i % 8) < 4);
      #2;
      if (i == 9) chk("l1_early", 32'(lk1), 0);
      if (i == 10) begin
        chk("l1_lk", 32'(lk1), 1);
        chk("l1_sel", 32'(sel1), 2);
        chk("l1_per", 32'(per1), 8);
      end
    end

    for (int s = 0; s < 60; s++) begin
      int r;
      logic v;
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        run_clk(ptab[$urandom_range(0, 11)], $urandom_range(1, 6));
      end else if (r == 6) begin
        v = 1'($urandom_range(0, 1));
        repeat ($urandom_range(10, 90)) cyc(v);
      end else if (r == 7) begin
        repeat ($urandom_range(5, 30)) cyc(1'($urandom_range(0, 1)));
      end else if (r == 8) begin
        async_rst($urandom_range(1, 4));
      end else begin
        run_clk(ptab[$urandom_range(0, 3)], $urandom_range(3, 8));
      end
    end
    run_clk(4, 3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
